// File: rtl/ow_pkg.sv
// Shared definitions for the one-wire blocks: state encoding, default slot
// timing and counter-width helpers.
package ow_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    SLOT      = 2'd2,
    HOLD      = 2'd3
  } ow_state_e;

  localparam int FRAME_BITS_DEF     = 8;
  localparam int SLOT_CYCLES_DEF    = 71;
  localparam int SAMPLE_OFFSET_DEF  = 30;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ow_frame_receiver_if.sv
// Frame delivery handshake between the one-wire receiver and its consumer.
interface ow_frame_receiver_if #(
  parameter int FRAME_BITS = 8
);
  logic [FRAME_BITS-1:0] frame;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  done_recieving;

  modport master (
    output frame,
    output frame_valid,
    output done_recieving,
    input  frame_ready
  );

  modport slave (
    input  frame,
    input  frame_valid,
    input  done_recieving,
    output frame_ready
  );
endinterface

// File: rtl/ow_bus_sync.sv
// Two-flop synchroniser for the one-wire line plus falling-edge detect.
// Flops reset to 1 (idle line level) so reset release never fakes a fall.
module ow_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic bus_s,
  output logic fall
);
  logic meta_reg;
  logic sync_reg;
  logic sync_q_reg;

  // Synchronise the line and keep a one-cycle delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg   <= 1'b1;
      sync_reg   <= 1'b1;
      sync_q_reg <= 1'b1;
    end else begin
      meta_reg   <= line;
      sync_reg   <= meta_reg;
      sync_q_reg <= sync_reg;
    end
  end

  assign bus_s = sync_reg;
  assign fall  = sync_q_reg & ~sync_reg;
endmodule

// File: rtl/ow_frame_receiver.sv
// One-wire frame receiver: re-synchronises on each slot falling edge, samples
// each bit SAMPLE_OFFSET cycles in, assembles an LSB-first frame and offers it
// on a valid/ready handshake. Optional macro OW_RX_PARITY_EN adds an even
// parity slot after the data bits and reports the result on parity_err.
module ow_frame_receiver
  import ow_pkg::*;
#(
  parameter int FRAME_BITS     = FRAME_BITS_DEF,
  parameter int SLOT_CYCLES    = SLOT_CYCLES_DEF,
  parameter int SAMPLE_OFFSET  = SAMPLE_OFFSET_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  bus,
  input  logic                 en_cmd_recieve,
  ow_frame_receiver_if.master  rx,
  output logic                 timeout,
  output logic                 overrun,
  output logic                 parity_err
);

`ifdef OW_RX_PARITY_EN
  localparam int TOTAL_BITS = FRAME_BITS + 1;
`else
  localparam int TOTAL_BITS = FRAME_BITS;
`endif

  localparam int SW = cnt_width(SLOT_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int BW = cnt_width(FRAME_BITS + 1);

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_AT  = SW'(SAMPLE_OFFSET);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(TOTAL_BITS - 1);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_WAIT_FALL = WAIT_FALL;
  localparam logic [1:0] ST_SLOT      = SLOT;
  localparam logic [1:0] ST_HOLD      = HOLD;

  // The receiver only listens; the line is released permanently.
  assign bus = 1'bz;

  logic bus_s;
  logic fall;

  ow_bus_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (bus),
    .bus_s (bus_s),
    .fall  (fall)
  );

  logic [1:0]            state_reg;
  logic [SW-1:0]         slot_cnt_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic [TOTAL_BITS-1:0] shift_reg;
  logic [TOTAL_BITS-1:0] shift_next;
  logic [FRAME_BITS-1:0] frame_reg;
  logic                  valid_reg;
  logic                  done_reg;
  logic                  timeout_reg;
  logic                  overrun_reg;
`ifdef OW_RX_PARITY_EN
  logic                  parity_reg;
`endif

  // New bits enter at the top so the first bit on the wire ends up in bit 0.
  always_comb begin
    shift_next                 = shift_reg >> 1;
    shift_next[TOTAL_BITS-1]   = bus_s;
  end

  // Receive state machine, frame register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      slot_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      frame_reg    <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
`ifdef OW_RX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (en_cmd_recieve) begin
            state_reg   <= ST_WAIT_FALL;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
          end
        end
        ST_WAIT_FALL: begin
          if (!en_cmd_recieve) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
          end else if (fall) begin
            // A fall on the last allowed cycle still counts as a slot start.
            state_reg    <= ST_SLOT;
            slot_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_SLOT: begin
          if (!en_cmd_recieve) begin
            state_reg    <= ST_IDLE;
            slot_cnt_reg <= '0;
          end else begin
            if (slot_cnt_reg == SAMPLE_AT) begin
              shift_reg <= shift_next;
            end
            if (slot_cnt_reg == SLOT_LAST) begin
              slot_cnt_reg <= '0;
              if (bit_cnt_reg == BIT_LAST) begin
                // Sample point is strictly before the slot end, so shift_reg
                // already holds the complete frame here.
                state_reg   <= ST_HOLD;
                bit_cnt_reg <= '0;
                frame_reg   <= shift_reg[FRAME_BITS-1:0];
                valid_reg   <= 1'b1;
                done_reg    <= 1'b1;
`ifdef OW_RX_PARITY_EN
                parity_reg  <= ^shift_reg;
`endif
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                state_reg   <= ST_WAIT_FALL;
              end
            end else begin
              slot_cnt_reg <= slot_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          // HOLD: line data is ignored, but a new slot start means lost data.
          if (fall) begin
            overrun_reg <= 1'b1;
          end
          if (rx.frame_ready) begin
            valid_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            state_reg   <= en_cmd_recieve ? ST_WAIT_FALL : ST_IDLE;
`ifdef OW_RX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign rx.frame          = frame_reg;
  assign rx.frame_valid    = valid_reg;
  assign rx.done_recieving = done_reg;
  assign timeout           = timeout_reg;
  assign overrun           = overrun_reg;
`ifdef OW_RX_PARITY_EN
  assign parity_err        = parity_reg;
`else
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ow_frame_receiver.sv
// Self-checking bench for ow_frame_receiver: table-driven frames checked by a
// scoreboard on done_recieving, plus hand-written overrun, timeout, reset and
// sample-point sequences.
module tb_ow_frame_receiver;
  import ow_pkg::*;

  localparam int FB  = 8;
  localparam int SC  = 71;
  localparam int SO  = 30;
  localparam int TC  = 1000;
  // Slot period on the line: slot length plus recovery so the next fall is
  // seen after the receiver has left SLOT.
  localparam int SLOT_PERIOD = SC + 4;
  // Line low time for a 1 / 0 bit in normal frames.
  localparam int LOW1 = 6;
  localparam int LOW0 = 60;
  // Slot cycle k (counted from slot_cnt = 0) corresponds to line cycle k + 1,
  // line cycle 0 being the falling edge itself.
  localparam int GLITCH_HI = SO + 1;  // low in slot cycles 0..SO-1
  localparam int GLITCH_LO = SO + 2;  // low in slot cycles 0..SO

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic bus_drv = 1'b1;
  wire  bus;
  logic timeout;
  logic overrun;
  logic parity_err;

  assign bus = bus_drv;

  ow_frame_receiver_if #(.FRAME_BITS(FB)) rx_if ();

  ow_frame_receiver #(
    .FRAME_BITS    (FB),
    .SLOT_CYCLES   (SC),
    .SAMPLE_OFFSET (SO),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .en_cmd_recieve (en),
    .rx             (rx_if),
    .timeout        (timeout),
    .overrun        (overrun),
    .parity_err     (parity_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [FB-1:0] data;
    logic          par;
    logic [FB-1:0] exp_frame;
    logic          exp_perr;
  } vec_t;

  typedef struct {
    logic [FB-1:0] data;
    logic          perr;
  } exp_t;

  exp_t sb_q[$];
  int   frames_seen   = 0;
  int   valid_cnt     = 0;
  int   done_cnt      = 0;
  int   rst_pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard: each completed frame is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_if.done_recieving || timeout) rst_pulse_cnt++;
    end else begin
      if (rx_if.frame_valid) valid_cnt++;
      if (rx_if.done_recieving) begin
        done_cnt++;
        frames_seen++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_frame", {24'd0, rx_if.frame}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_frame", {24'd0, rx_if.frame}, {24'd0, e.data});
          check("sb_parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("sb_valid_with_done", {31'd0, rx_if.frame_valid}, 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_slot(input logic b, input int l1, input int l0);
    int low;
    low = b ? l1 : l0;
    bus_drv = 1'b0;
    repeat (low) @(negedge clk);
    bus_drv = 1'b1;
    repeat (SLOT_PERIOD - low) @(negedge clk);
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic par, input int l1, input int l0);
    for (int i = 0; i < FB; i++) send_slot(d[i], l1, l0);
`ifdef OW_RX_PARITY_EN
    send_slot(par, l1, l0);
`else
    if (par === 1'bx) $display("note: parity bit unknown");
`endif
    tick(3);
  endtask

  task automatic expect_frame(input logic [FB-1:0] d, input logic perr);
    exp_t e;
    e.data = d;
`ifdef OW_RX_PARITY_EN
    e.perr = perr;
`else
    e.perr = 1'b0 & perr;
`endif
    sb_q.push_back(e);
  endtask

  vec_t vecs[8];

  initial begin
    int first_tmo;
    int tmo_cnt;
    int seen_before;

    vecs[0] = '{8'h07, 1'b1, 8'h07, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 8'h81, 1'b0};
    vecs[6] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 8'h5A, 1'b1};

    rx_if.frame_ready = 1'b1;
    tick(5);
    check("rst_frame", {24'd0, rx_if.frame}, 32'd0);
    check("rst_valid", {31'd0, rx_if.frame_valid}, 32'd0);
    check("rst_done", {31'd0, rx_if.done_recieving}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    tick(2);

    // 0xA5 with the consumer always ready: one-cycle valid and done.
    en = 1'b1;
    tick(2);
    valid_cnt = 0;
    done_cnt  = 0;
    expect_frame(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0, LOW1, LOW0);
    tick(5);
    check("a5_valid_cycles", valid_cnt, 32'd1);
    check("a5_done_cycles", done_cnt, 32'd1);
    check("a5_frame_held", {24'd0, rx_if.frame}, 32'hA5);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      expect_frame(vecs[i].exp_frame, vecs[i].exp_perr);
      send_frame(vecs[i].data, vecs[i].par, LOW1, LOW0);
    end
    tick(5);
    check("table_sb_empty", sb_q.size(), 32'd0);
    check("table_frames_seen", frames_seen, 32'd9);

    // Overrun: consumer stalls, then a new slot start arrives.
    rx_if.frame_ready = 1'b0;
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, LOW1, LOW0);
    tick(200);
    check("ovr_valid_held", {31'd0, rx_if.frame_valid}, 32'd1);
    check("ovr_before_fall", {31'd0, overrun}, 32'd0);
    bus_drv = 1'b0;
    tick(LOW1);
    bus_drv = 1'b1;
    tick(5);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_frame_kept", {24'd0, rx_if.frame}, 32'h3C);
    rx_if.frame_ready = 1'b1;
    tick(2);
    check("ovr_valid_dropped", {31'd0, rx_if.frame_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    check("ovr_frame_after_hs", {24'd0, rx_if.frame}, 32'h3C);

    // Idle timeout: pulse TC cycles after entering WAIT_FALL.
    en = 1'b0;
    tick(3);
    seen_before = frames_seen;
    valid_cnt = 0;
    en = 1'b1;
    first_tmo = -1;
    tmo_cnt = 0;
    for (int i = 1; i <= TC + 100; i++) begin
      @(negedge clk);
      if (timeout) begin
        tmo_cnt++;
        if (first_tmo < 0) first_tmo = i;
      end
    end
    en = 1'b0;
    check("tmo_cycle", first_tmo, TC + 1);
    check("tmo_pulse_width", tmo_cnt, 32'd1);
    check("tmo_no_valid", valid_cnt, 32'd0);
    check("tmo_no_frame", frames_seen - seen_before, 32'd0);
    check("tmo_overrun_sticky", {31'd0, overrun}, 32'd1);
    tick(3);

    // Reset in the middle of 0xFF, then a clean 0x01.
    en = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) send_slot(1'b1, LOW1, LOW0);
    rst = 1'b1;
    tick(3);
    check("mrst_no_pulses", rst_pulse_cnt, 32'd0);
    check("mrst_valid", {31'd0, rx_if.frame_valid}, 32'd0);
    check("mrst_overrun_clr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    tick(2);
    expect_frame(8'h01, 1'b0);
    send_frame(8'h01, 1'b1, LOW1, LOW0);
    tick(5);

    // Sample point: low through slot cycle SO-1 reads 1, through SO reads 0.
    expect_frame(8'hFF, 1'b0);
    send_frame(8'hFF, 1'b0, GLITCH_HI, GLITCH_LO);
    expect_frame(8'hF7, 1'b0);
    send_frame(8'hF7, 1'b1, GLITCH_HI, GLITCH_LO);
    expect_frame(8'h00, 1'b0);
    send_frame(8'h00, 1'b0, GLITCH_HI, GLITCH_LO);
    tick(10);
    check("final_sb_empty", sb_q.size(), 32'd0);
    check("final_frames_seen", frames_seen, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
